patch_scan_ctrl: RTL and testbench

- Upstream sequencer for the 3x3 patch latch stage of the conv layer.
- Walks a 3x3 window over an IMG_W x IMG_H image held in synchronous-read image memory, column by column, top to bottom.
- Drives the nine pixel addresses plus the load/load_full_patch strobes the latch consumes.
- Flags when the latched patch is valid and stalls on downstream backpressure.

---
 rtl/patch_scan_ctrl_if.sv | 28 ++
 rtl/patch_scan_ctrl.sv | 106 ++++++++++
 tb/tb_patch_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/patch_scan_ctrl_if.sv
// Handshake and address bundle between the patch scan sequencer and the 3x3 patch latch.
// i_* signals flow into the sequencer, o_* signals flow out of it.
interface patch_scan_ctrl_if #(
   parameter int ADDR_W = 10
) ();
   logic              i_start;
   logic              i_ready;
   logic [ADDR_W-1:0] o_pixel_addr [9];
   logic              o_load;
   logic              o_load_full_patch;
   logic              o_patch_valid;
   logic [ADDR_W-1:0] o_out_row;
   logic [ADDR_W-1:0] o_out_col;
   logic              o_busy;
   logic              o_done;

   modport master (
      input  i_start, i_ready,
      output o_pixel_addr, o_load, o_load_full_patch, o_patch_valid,
             o_out_row, o_out_col, o_busy, o_done
   );

   modport slave (
      output i_start, i_ready,
      input  o_pixel_addr, o_load, o_load_full_patch, o_patch_valid,
             o_out_row, o_out_col, o_busy, o_done
   );
endinterface

// File: rtl/patch_scan_ctrl.sv
// Walks a 3x3 window column by column over the image, issuing nine pixel addresses
// and latch strobes, then holds each patch valid until downstream accepts it.
module patch_scan_ctrl #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10
) (
   input  logic            clk,
   input  logic            rst,
   patch_scan_ctrl_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_VALID = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] W_IMG    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 3);

   logic [2:0]        r_state, w_state_next;
   logic [ADDR_W-1:0] r_row, w_row_next;
   logic [ADDR_W-1:0] r_col, w_col_next;
   logic              r_full, w_full_next;
   logic [ADDR_W-1:0] r_addr      [9];
   logic [ADDR_W-1:0] w_addr_next [9];

   always_comb begin
      w_state_next = r_state;
      w_row_next   = r_row;
      w_col_next   = r_col;
      w_full_next  = r_full;
      case (r_state)
         S_IDLE: begin
            if (bus.i_start) begin
               w_state_next = S_ADDR;
               w_row_next   = '0;
               w_col_next   = '0;
               w_full_next  = 1'b1;
            end
         end
         S_ADDR:  w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_VALID;
         S_VALID: begin
            if (bus.i_ready) begin
               if (r_row == LAST_ROW && r_col == LAST_COL) begin
                  w_state_next = S_DONE;
               end else if (r_row == LAST_ROW) begin
                  // New column: the latch has nothing to shift from, so reload all nine
                  w_state_next = S_ADDR;
                  w_row_next   = '0;
                  w_col_next   = r_col + 1'b1;
                  w_full_next  = 1'b1;
               end else begin
                  w_state_next = S_ADDR;
                  w_row_next   = r_row + 1'b1;
                  w_full_next  = 1'b0;
               end
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_full  <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_row   <= w_row_next;
         r_col   <= w_col_next;
         r_full  <= w_full_next;
      end
   end

   // Addresses are computed from the upcoming window origin and only change on entry to ADDR
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_addr
         assign w_addr_next[gi] = (w_row_next + ADDR_W'(gi / 3)) * W_IMG
                                + w_col_next + ADDR_W'(gi % 3);

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_addr[gi] <= '0;
            end else if (w_state_next == S_ADDR) begin
               r_addr[gi] <= w_addr_next[gi];
            end
         end

         assign bus.o_pixel_addr[gi] = r_addr[gi];
      end
   endgenerate

   assign bus.o_load            = (r_state == S_LOAD);
   assign bus.o_load_full_patch = (r_state == S_LOAD) && r_full;
   assign bus.o_patch_valid     = (r_state == S_VALID);
   assign bus.o_out_row         = (r_state == S_VALID) ? r_row : '0;
   assign bus.o_out_col         = (r_state == S_VALID) ? r_col : '0;
   assign bus.o_busy            = (r_state == S_ADDR) || (r_state == S_LOAD) || (r_state == S_VALID);
   assign bus.o_done            = (r_state == S_DONE);
endmodule

// File: tb/tb_patch_scan_ctrl.sv
// Scoreboard bench for patch_scan_ctrl: expected patch order is generated from the
// scan rules and checked by a negedge monitor; directed phases cover latency, stall, abort.
module tb_patch_scan_ctrl;
   localparam int W  = 28;
   localparam int H  = 28;
   localparam int AW = 10;
   localparam int SW = 4;
   localparam int SH = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   patch_scan_ctrl_if #(.ADDR_W(AW)) u_if ();
   patch_scan_ctrl_if #(.ADDR_W(AW)) u_small_if ();

   patch_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
   );

   patch_scan_ctrl #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(AW)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (u_small_if.master)
   );

   typedef struct {
      int row;
      int col;
      bit full;
   } patch_t;

   patch_t exp_q[$];
   int     checks = 0;
   int     failures = 0;
   int     acc_cnt = 0;
   int     full_cnt = 0;
   int     done_cnt = 0;
   int     arm_cnt = 0;
   int     arm_seen = 0;
   bit     mon_en = 1'b0;
   bit     last_acc_prev = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int ref_addr(input int img_w, input int row, input int col, input int k);
      return (row + k / 3) * img_w + col + k % 3;
   endfunction

   // Monitor: sole owner of the expected queue and the per-scan counters
   always @(negedge clk) begin : mon
      bit acc_last;
      acc_last = 1'b0;
      if (arm_cnt != arm_seen) begin
         arm_seen = arm_cnt;
         exp_q.delete();
         acc_cnt = 0;
         full_cnt = 0;
         done_cnt = 0;
         last_acc_prev = 1'b0;
         for (int c = 0; c <= W - 3; c++)
            for (int r = 0; r <= H - 3; r++)
               exp_q.push_back('{r, c, (r == 0)});
      end
      if (mon_en) begin
         chk("mutex", int'($countones({u_if.o_load, u_if.o_patch_valid, u_if.o_done}) <= 1), 1);
         if (u_if.o_load) begin
            if (exp_q.size() == 0) begin
               chk("load_unexpected", 1, 0);
            end else begin
               chk("load_full", int'(u_if.o_load_full_patch), int'(exp_q[0].full));
               for (int k = 0; k < 9; k++)
                  chk("load_addr", int'(u_if.o_pixel_addr[k]), ref_addr(W, exp_q[0].row, exp_q[0].col, k));
               if (u_if.o_load_full_patch) full_cnt++;
            end
         end
         if (u_if.o_patch_valid) begin
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", 1, 0);
            end else begin
               chk("out_row", int'(u_if.o_out_row), exp_q[0].row);
               chk("out_col", int'(u_if.o_out_col), exp_q[0].col);
               for (int k = 0; k < 9; k++)
                  chk("valid_addr", int'(u_if.o_pixel_addr[k]), ref_addr(W, exp_q[0].row, exp_q[0].col, k));
               if (u_if.i_ready) begin
                  void'(exp_q.pop_front());
                  acc_cnt++;
                  if (exp_q.size() == 0) acc_last = 1'b1;
               end
            end
         end else begin
            chk("out_row_idle", int'(u_if.o_out_row), 0);
            chk("out_col_idle", int'(u_if.o_out_col), 0);
         end
         if (u_if.o_done) begin
            done_cnt++;
            chk("done_after_last", int'(last_acc_prev), 1);
         end
         last_acc_prev = acc_last;
      end
   end

   int exp_a0[9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
   int got_r[$];
   int got_c[$];

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"},  int'(u_if.o_busy), 0);
      chk({name, "_load"},  int'(u_if.o_load), 0);
      chk({name, "_full"},  int'(u_if.o_load_full_patch), 0);
      chk({name, "_valid"}, int'(u_if.o_patch_valid), 0);
      chk({name, "_done"},  int'(u_if.o_done), 0);
      chk({name, "_row"},   int'(u_if.o_out_row), 0);
      chk({name, "_col"},   int'(u_if.o_out_col), 0);
      for (int k = 0; k < 9; k++)
         chk({name, "_addr"}, int'(u_if.o_pixel_addr[k]), 0);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 u_if.i_start = 1'b1;
      @(posedge clk); #1 u_if.i_start = 1'b0;
   endtask

   initial begin
      bit seen;
      bit small_done;
      u_if.i_start = 1'b0;
      u_if.i_ready = 1'b0;
      u_small_if.i_start = 1'b0;
      u_small_if.i_ready = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      chk("reset_small_busy", int'(u_small_if.o_busy), 0);
      @(posedge clk); #1 rst = 1'b1;

      // Scan 1: latency, stall and shift checks, then randomized backpressure
      arm_cnt++;
      mon_en = 1'b1;
      @(negedge clk);
      pulse_start();
      @(negedge clk);
      chk("addr_busy", int'(u_if.o_busy), 1);
      chk("addr_load", int'(u_if.o_load), 0);
      chk("addr_valid", int'(u_if.o_patch_valid), 0);
      for (int k = 0; k < 9; k++) chk("first_addr", int'(u_if.o_pixel_addr[k]), exp_a0[k]);
      @(negedge clk);
      chk("first_load", int'(u_if.o_load), 1);
      chk("first_load_full", int'(u_if.o_load_full_patch), 1);
      @(negedge clk);
      chk("first_valid", int'(u_if.o_patch_valid), 1);
      chk("first_row", int'(u_if.o_out_row), 0);
      chk("first_col", int'(u_if.o_out_col), 0);
      repeat (4) begin
         @(posedge clk); #1 u_if.i_start = 1'b1;
         @(negedge clk);
         chk("hold_valid", int'(u_if.o_patch_valid), 1);
         chk("hold_load", int'(u_if.o_load), 0);
         chk("hold_row", int'(u_if.o_out_row), 0);
         chk("hold_col", int'(u_if.o_out_col), 0);
         for (int k = 0; k < 9; k++) chk("hold_addr", int'(u_if.o_pixel_addr[k]), exp_a0[k]);
      end
      @(posedge clk); #1 u_if.i_start = 1'b0; u_if.i_ready = 1'b1;
      @(negedge clk);
      chk("rise_valid", int'(u_if.o_patch_valid), 1);
      @(posedge clk); #1 u_if.i_ready = 1'b0;
      @(negedge clk);
      chk("adv_valid", int'(u_if.o_patch_valid), 0);
      chk("adv_busy", int'(u_if.o_busy), 1);
      chk("shift_addr6", int'(u_if.o_pixel_addr[6]), 84);
      chk("shift_addr7", int'(u_if.o_pixel_addr[7]), 85);
      chk("shift_addr8", int'(u_if.o_pixel_addr[8]), 86);
      @(negedge clk);
      chk("shift_load", int'(u_if.o_load), 1);
      chk("shift_full", int'(u_if.o_load_full_patch), 0);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(posedge clk); #1;
         if (done_cnt > 0) break;
         u_if.i_ready = ($urandom_range(0, 3) != 0);
         u_if.i_start = ($urandom_range(0, 15) == 0);
      end
      u_if.i_start = 1'b0;
      u_if.i_ready = 1'b0;
      @(negedge clk);
      chk("scan1_busy_after", int'(u_if.o_busy), 0);
      chk("scan1_done_after", int'(u_if.o_done), 0);
      chk("scan1_done_cnt", done_cnt, 1);
      chk("scan1_patches", acc_cnt, (W - 2) * (H - 2));
      chk("scan1_full_loads", full_cnt, W - 2);
      chk("scan1_queue_left", exp_q.size(), 0);

      // Abort in LOAD
      mon_en = 1'b0;
      u_if.i_ready = 1'b1;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (u_if.o_load) begin
            seen = 1'b1;
            break;
         end
      end
      chk("abort_load_seen", int'(seen), 1);
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("abort");
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", int'(u_if.o_done), 0);
         chk("abort_idle", int'(u_if.o_busy), 0);
      end

      // Scan 2: restart after abort with ready tied high
      arm_cnt++;
      @(negedge clk);
      mon_en = 1'b1;
      pulse_start();
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(posedge clk); #1;
         if (done_cnt > 0) break;
      end
      @(negedge clk);
      chk("scan2_done_cnt", done_cnt, 1);
      chk("scan2_patches", acc_cnt, (W - 2) * (H - 2));
      chk("scan2_full_loads", full_cnt, W - 2);
      chk("scan2_busy_after", int'(u_if.o_busy), 0);
      mon_en = 1'b0;

      // Small image: order of patch origins
      @(posedge clk); #1 u_small_if.i_start = 1'b1;
      @(posedge clk); #1 u_small_if.i_start = 1'b0;
      small_done = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (u_small_if.o_patch_valid) begin
            got_r.push_back(int'(u_small_if.o_out_row));
            got_c.push_back(int'(u_small_if.o_out_col));
         end
         if (u_small_if.o_done) begin
            small_done = 1'b1;
            break;
         end
      end
      chk("small_done", int'(small_done), 1);
      chk("small_count", got_r.size(), (SW - 2) * (SH - 2));
      if (got_r.size() == (SW - 2) * (SH - 2)) begin
         int idx;
         idx = 0;
         for (int c = 0; c <= SW - 3; c++)
            for (int r = 0; r <= SH - 3; r++) begin
               chk("small_row", got_r[idx], r);
               chk("small_col", got_c[idx], c);
               idx++;
            end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
